alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle execution controller that sits directly upstream of the 8-entry × 8-bit register file. It accepts one 16-bit instruction per handshake and drives the file's read selects (`asel`/`bsel`). It latches the returned operands, computes an 8-bit ALU result, and writes it back through `csel`/`cload`/`cin`. It also owns the zero/carry flags and reports completion to the instruction source.

## Interface
- `clk`  in  1  single system clock; all state changes on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr_valid`  in  1  instruction source has a word on `instr`
- `instr_ready`  out  1  sequencer can accept; high only in IDLE
- `instr`  in  16  `[15:12]` op, `[11:9]` dst c, `[8:6]` src a, `[5:3]` src b, `[7:0]` imm8 (LDI only)
- `asel`, `bsel`  out  3  register-file read selects
- `aout`, `bout`  in  8  register-file read data, combinational from the selects
- `csel`  out  3  register-file write select
- `cload`  out  1  register-file write enable, one cycle per write
- `cin`  out  8  register-file write data
- `flag_z`, `flag_c`  out  1  zero and carry flags
- `done`  out  1  one-cycle pulse when an instruction retires
- `illegal`  out  1  sticky; set on an unsupported opcode, cleared by reset only

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD: a+b, C = carry out
  - 2 SUB: a−b, C = borrow (a<b)
  - 3 AND, 4 OR, 5 XOR: C = 0
  - 6 SHL: a<<1, C = a[7]
  - 7 SHR: a>>1 logical, C = a[0]
  - 8 LDI: c = imm8
  - 9 MOV: c = a
  - 10 MUL: low byte of a×b, C = (high byte ≠ 0); macro-gated
  - 11–15: illegal, executed as NOP
- Z = (result == 0) for opcodes 1–7 and MUL. LDI, MOV and NOP leave both flags unchanged.
- All arithmetic is 8-bit wrap-around. Internal sums are 9 bits wide so the carry can be taken from them.
- FSM states:
  - IDLE: `instr_ready`=1. On `instr_valid`, latch `instr` → READ.
  - READ: drive `asel`=a, `bsel`=b; capture `aout`/`bout` into operand registers → EXEC.
  - EXEC: compute result and flags → WRITE. MUL instead stays here for 8 cycles.
  - WRITE: `csel`=c, `cin`=result, `cload`=1 unless NOP/illegal; `done`=1; flags update → IDLE.
- `asel`/`bsel` hold their last value outside READ. `csel`/`cin` hold outside WRITE; `cload` is 0 outside WRITE.
- Read-after-write: the write commits on the WRITE edge, and the next READ comes at least 2 cycles later, so it observes the new value. No bypass is needed.
- a = c is legal. The operand is captured in READ, and the write occurs in WRITE.

## Timing
- Reset values: IDLE state; `instr_ready`, `asel`, `bsel`, `csel`, `cload`, `cin`, `flag_z`, `flag_c`, `done`, `illegal` all 0.
- `instr_ready` is registered: 0 during reset, 1 from the first edge after `rst` deasserts.
- Handshake: transfer occurs on the edge where `instr_valid` & `instr_ready`. `instr` is sampled only at that edge. `instr_valid` may drop afterwards without effect.
- Latency, with accept at edge T:
  - READ in cycle T+1, EXEC in T+2, WRITE in T+3.
  - The register-file write commits at the end of T+3, and `done` is high during T+3.
  - `instr_ready` is high again in T+4.
- Throughput is 1 instruction per 4 cycles; MUL takes 11 cycles.
- Reset asserted mid-instruction asynchronously forces IDLE and drops `cload` in the same cycle. No partial write or flag update occurs, and the instruction is discarded.
- `instr_valid` held high continuously means back-to-back instructions are accepted on every IDLE cycle.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - Opcode 10 runs an iterative shift-add multiplier, one bit per EXEC cycle, 8 cycles.
  - `done` asserts 11 cycles after accept.
- `ALU_SEQ_MUL_EN` undefined:
  - Opcode 10 is illegal: no write, flags unchanged, `illegal` set.
  - No multiplier logic is synthesised.

## Structure
- Package `alu_seq_pkg` holds:
  - opcode constants (`OP_NOP`…`OP_MUL`)
  - FSM state encoding (IDLE/READ/EXEC/WRITE)
  - instruction field bit positions
  - data width 8 and register-select width 3
- Sub-module `alu_seq_mul`: 8-bit iterative multiplier.
  - Interface: `clk`, `rst`, `start`, `a`, `b`, `busy`, `prod[15:0]`.
  - Instantiated only under `ALU_SEQ_MUL_EN`.
- ALU datapath and FSM stay in `alu_sequencer`.

## Test plan
- Reset: assert `rst` mid-cycle → all outputs 0 immediately. After release, `instr_ready`=1 on the next edge.
- Accept LDI r3,0x5A at edge T → `cload`=1, `csel`=3, `cin`=0x5A and `done`=1 in T+3. Flags unchanged.
- r1=0xF0, r2=0x20, ADD r4,r1,r2 → `cin`=0x10, `flag_c`=1, `flag_z`=0. Then SUB r5,r2,r2 → `cin`=0x00, `flag_z`=1, `flag_c`=0.
- Back-to-back LDI r1,7 then MOV r2,r1 with `instr_valid` held high → the MOV's READ sees 7 and writes `cin`=7. Accepts are exactly 4 cycles apart.
- Opcode 10 with r1=0x10, r2=0x11:
  - with macro → `cin`=0x10, `flag_c`=1, `done` 11 cycles after accept
  - without macro → `cload` stays 0, `illegal`=1
- Assert `rst` during an ADD's EXEC cycle → no `cload` pulse, target register unchanged, FSM in IDLE and `instr_ready` high after release.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared widths, opcodes, FSM states and instruction field positions for alu_sequencer.
package alu_seq_pkg;
    localparam int DW = 8;
    localparam int SW = 3;
    localparam int OP_LSB = 12;
    localparam int C_LSB  = 9;
    localparam int A_LSB  = 6;
    localparam int B_LSB  = 3;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
endpackage

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: 8x8 shift-add multiplier, one multiplier bit per cycle; busy for 8 cycles after start.
module alu_seq_mul
    import alu_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            busy,
    output logic [2*DW-1:0] prod
);
    logic [2*DW-1:0] r_mcand;
    logic [DW-1:0]   r_mplier;
    logic [3:0]      r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            prod     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            prod     <= '0;
            r_mcand  <= {{DW{1'b0}}, a};
            r_mplier <= b;
            r_cnt    <= 4'(DW);
        end else if (busy) begin
            prod     <= r_mplier[0] ? prod + r_mcand : prod;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - 4'd1;
            busy     <= r_cnt != 4'd1;
        end
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/READ/EXEC/WRITE controller driving an 8x8 register file, owning Z/C flags.
// Define ALU_SEQ_MUL_EN to make opcode 10 an iterative multiply; otherwise it is illegal.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [SW-1:0] asel,
    output logic [SW-1:0] bsel,
    input  logic [DW-1:0] aout,
    input  logic [DW-1:0] bout,
    output logic [SW-1:0] csel,
    output logic          cload,
    output logic [DW-1:0] cin,
    output logic          flag_z,
    output logic          flag_c,
    output logic          done,
    output logic          illegal
);
    state_t        r_state;
    logic [15:0]   r_instr;
    logic [DW-1:0] r_a, r_b, w_res;
    logic [DW:0]   w_add, w_sub;
    logic [3:0]    w_op;
    logic          w_cy, w_flags, w_wr, w_ill, w_wait;

    assign w_op  = r_instr[OP_LSB +: 4];
    assign w_add = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} - {1'b0, r_b};
`ifdef ALU_SEQ_MUL_EN
    logic            w_mul_busy;
    logic [2*DW-1:0] w_prod;
    // Multiplier starts from the live read data so its 8 steps overlap the EXEC wait.
    alu_seq_mul u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (r_state == S_READ && w_op == OP_MUL),
        .a     (aout),
        .b     (bout),
        .busy  (w_mul_busy),
        .prod  (w_prod)
    );
    assign w_wait = (w_op == OP_MUL) && w_mul_busy;
`else
    assign w_wait = 1'b0;
`endif

    always_comb begin
        w_res   = '0;
        w_cy    = 1'b0;
        w_flags = 1'b1;
        w_wr    = 1'b1;
        w_ill   = 1'b0;
        case (w_op)
            OP_ADD: {w_cy, w_res} = w_add;
            OP_SUB: {w_cy, w_res} = w_sub;
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_SHL: {w_cy, w_res} = {r_a, 1'b0};
            OP_SHR: {w_res, w_cy} = {1'b0, r_a};
            OP_LDI: begin w_res = r_instr[DW-1:0]; w_flags = 1'b0; end
            OP_MOV: begin w_res = r_a; w_flags = 1'b0; end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin w_res = w_prod[DW-1:0]; w_cy = |w_prod[2*DW-1:DW]; end
`endif
            OP_NOP: begin w_wr = 1'b0; w_flags = 1'b0; end
            default: begin w_wr = 1'b0; w_flags = 1'b0; w_ill = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_instr     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            instr_ready <= 1'b0;
            asel        <= '0;
            bsel        <= '0;
            csel        <= '0;
            cload       <= 1'b0;
            cin         <= '0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            cload <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                S_IDLE: if (instr_ready && instr_valid) begin
                    r_instr     <= instr;
                    asel        <= instr[A_LSB +: SW];
                    bsel        <= instr[B_LSB +: SW];
                    instr_ready <= 1'b0;
                    r_state     <= S_READ;
                end else begin
                    instr_ready <= 1'b1;
                end
                S_READ: begin
                    r_a     <= aout;
                    r_b     <= bout;
                    r_state <= S_EXEC;
                end
                // Write-side outputs are registered here so they are valid throughout WRITE.
                S_EXEC: if (!w_wait) begin
                    if (w_wr) begin
                        csel <= r_instr[C_LSB +: SW];
                        cin  <= w_res;
                    end
                    if (w_flags) begin
                        flag_z <= w_res == '0;
                        flag_c <= w_cy;
                    end
                    cload   <= w_wr;
                    done    <= 1'b1;
                    illegal <= illegal | w_ill;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    instr_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and randomized checks of alu_sequencer against an instruction-level model.
module tb_alu_sequencer;
    logic        clk = 1'b0, rst = 1'b1, instr_valid = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        instr_ready, cload, flag_z, flag_c, done, illegal;
    logic [2:0]  asel, bsel, csel;
    logic [7:0]  aout, bout, cin;
    logic [7:0]  regs [8] = '{default: 8'h00};
    logic [7:0]  mregs [8] = '{default: 8'h00};
    int          checks = 0, fails = 0;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    assign aout = regs[asel];
    assign bout = regs[bsel];
    always @(posedge clk) if (cload) regs[csel] <= cin;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .asel(asel), .bsel(bsel), .aout(aout), .bout(bout), .csel(csel), .cload(cload), .cin(cin),
        .flag_z(flag_z), .flag_c(flag_c), .done(done), .illegal(illegal)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Instruction-level model: one pending instruction, retired on its predicted done cycle.
    int         n, p_done, p_read;
    bit         armed, pending, p_wr, p_upd, p_ill, p_z, p_cy, m_z, m_c, m_ill;
    logic [2:0] p_c, p_a, p_b;
    logic [7:0] p_res;

    function automatic void predict(input logic [15:0] w);
        int a, b, r;
        bit cc;
        a = int'(mregs[w[8:6]]);
        b = int'(mregs[w[5:3]]);
        r = 0; cc = 0;
        p_wr = 1; p_upd = 1; p_ill = 0;
        p_c = w[11:9]; p_a = w[8:6]; p_b = w[5:3];
        case (int'(w[15:12]))
            0: begin p_wr = 0; p_upd = 0; end
            1: begin r = a + b; cc = r > 255; end
            2: begin r = a - b; cc = a < b; end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: begin r = a * 2; cc = a > 127; end
            7: begin r = a / 2; cc = (a % 2) == 1; end
            8: begin r = int'(w[7:0]); p_upd = 0; end
            9: begin r = a; p_upd = 0; end
            10: if (MUL_EN) begin r = a * b; cc = r > 255; end
                else begin p_wr = 0; p_upd = 0; p_ill = 1; end
            default: begin p_wr = 0; p_upd = 0; p_ill = 1; end
        endcase
        p_res = 8'(r & 255);
        p_z   = (r & 255) == 0;
        p_cy  = cc;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit rdy;
        if (rst) begin
            n = 0; armed = 0; pending = 0; m_z = 0; m_c = 0; m_ill = 0;
        end else begin
            rdy = armed && !pending;
            if (pending && n == p_done) begin
                if (p_wr) mregs[p_c] = p_res;
                if (p_upd) begin m_z = p_z; m_c = p_cy; end
                m_ill = m_ill | p_ill;
                pending = 0;
            end
            n++;
            if (rdy && instr_valid) begin
                predict(instr);
                p_read  = n;
                p_done  = n + ((instr[15:12] == 4'd10 && MUL_EN) ? 10 : 2);
                pending = 1;
            end
            armed = 1;
        end
    end

    always @(negedge clk) begin : cmp
        bit ed;
        if (!rst) begin
            ed = pending && n == p_done;
            chk("ready", instr_ready, armed && !pending);
            chk("done", done, ed);
            chk("cload", cload, ed && p_wr);
            if (pending && n == p_read) chk("read_sel", {asel, bsel}, {p_a, p_b});
            if (ed && p_wr) chk("write", {csel, cin}, {p_c, p_res});
            if (ed) chk("flags_wr", {flag_z, flag_c, illegal}, {p_upd ? p_z : m_z, p_upd ? p_cy : m_c, m_ill | p_ill});
            else chk("flags_hold", {flag_z, flag_c, illegal}, {m_z, m_c, m_ill});
        end
    end

    int acc_prev = 0, acc_last = 0, ncl = 0;
    always @(posedge clk) begin
        if (instr_ready && instr_valid) begin acc_prev = acc_last; acc_last = int'($time); end
        if (cload) ncl++;
    end

    int         g_lat;
    logic [7:0] g_cin;
    logic [2:0] g_csel;
    logic       g_cload, g_z, g_c, g_ill;

    function automatic logic [15:0] enc(input int op, input int c, input int a, input int b);
        return {4'(op), 3'(c), 3'(a), 3'(b), 3'b000};
    endfunction
    function automatic logic [15:0] ldi(input int c, input int imm);
        return {4'd8, 3'(c), 1'b0, 8'(imm)};
    endfunction

    task automatic wait_ready();
        int k;
        k = 0;
        while (!instr_ready && k < 20) begin @(negedge clk); k++; end
        chk("ready_wait", k < 20, 1);
    endtask

    task automatic issue(input logic [15:0] w);
        @(negedge clk);
        instr = w; instr_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        instr_valid = 1'b0;
        g_lat = 1;
        while (!done && g_lat < 15) begin @(negedge clk); g_lat++; end
        chk("done_seen", done, 1);
        g_cin = cin; g_csel = csel; g_cload = cload; g_z = flag_z; g_c = flag_c; g_ill = illegal;
    endtask

    task automatic outs_zero(input string nm);
        chk(nm, {instr_ready, asel, bsel, csel, cload, cin, flag_z, flag_c, done, illegal}, 0);
    endtask

    initial begin
        int dn;
        #7 outs_zero("reset_outs");
        #5 rst = 1'b0;
        chk("ready_before_edge", instr_ready, 0);
        #5 chk("ready_after_edge", instr_ready, 1);

        issue(ldi(3, 8'h5A));
        chk("ldi_lat", g_lat, 3);
        chk("ldi_write", {g_cload, g_csel, g_cin}, {1'b1, 3'd3, 8'h5A});
        chk("ldi_flags", {g_z, g_c}, 2'b00);

        issue(ldi(1, 8'hF0));
        issue(ldi(2, 8'h20));
        issue(enc(1, 4, 1, 2));
        chk("add_res", {g_cin, g_z, g_c}, {8'h10, 1'b0, 1'b1});
        issue(enc(2, 5, 2, 2));
        chk("sub_res", {g_cin, g_z, g_c}, {8'h00, 1'b1, 1'b0});

        @(negedge clk);
        instr = ldi(1, 7); instr_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        instr = enc(9, 2, 1, 0);
        dn = 0;
        for (int i = 0; i < 20 && dn < 2; i++) begin
            if (done) dn++;
            if (dn < 2) @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("b2b_mov", {dn[1:0], cload, csel, cin}, {2'd2, 1'b1, 3'd2, 8'h07});
        chk("b2b_gap", acc_last - acc_prev, 40);

        issue(ldi(1, 8'h10));
        issue(ldi(2, 8'h11));
        issue(enc(10, 6, 1, 2));
`ifdef ALU_SEQ_MUL_EN
        chk("mul_lat", g_lat, 11);
        chk("mul_res", {g_cload, g_cin, g_c, g_z}, {1'b1, 8'h10, 1'b1, 1'b0});
`else
        chk("mul_lat", g_lat, 3);
        chk("mul_illegal", {g_cload, g_ill}, 2'b01);
`endif

        dn = ncl;
        @(negedge clk);
        instr = enc(1, 4, 1, 2); instr_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 outs_zero("rst_exec_outs");
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_exec_ready", instr_ready, 1);
        repeat (3) @(negedge clk);
        chk("rst_exec_no_write", {ncl - dn, 24'(regs[4])}, {32'd0, 24'h10});

        repeat (3000) begin
            @(negedge clk);
            instr = 16'($urandom);
            instr_valid = ($urandom % 3) != 0;
            if ($urandom % 150 == 0) begin
                #1 rst = 1'b1;
                #1 outs_zero("rand_rst_outs");
                #1 rst = 1'b0;
            end
        end
        instr_valid = 1'b0;
        repeat (20) @(negedge clk);
        for (int i = 0; i < 8; i++) chk($sformatf("regfile_r%0d", i), regs[i], mregs[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
